countdown_timer_bcd: RTL and testbench
======================================

Name: countdown_timer_bcd

Overview:
MM:SS BCD down-counter for the multi-function digital clock. It is the decrementing counterpart of the clock's up-counting mod-6/mod-10 chain. The block accepts a preset time, counts down one second per 1 Hz tick, pauses and resumes on request, and raises an alarm (beep) window when it reaches 00:00. It sits beside the timekeeping counters, shares the 1 Hz enable, and drives the display mux and buzzer.

Parameters:
BEEP_SECS, 10, number of 1 Hz ticks the beep stays active after reaching 00:00 (legal range 1..63)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  1 Hz enable, single-cycle pulse synchronous to clk
load  in  1  load preset digits (level, sampled each cycle)
load_min_t  in  4  preset minutes tens, BCD 0..5
load_min_u  in  4  preset minutes units, BCD 0..9
load_sec_t  in  4  preset seconds tens, BCD 0..5
load_sec_u  in  4  preset seconds units, BCD 0..9
start  in  1  start/resume pulse; also acknowledges alarm
stop  in  1  pause pulse; also acknowledges alarm
clear  in  1  abort and zero the timer
min_t  out  4  current minutes tens
min_u  out  4  current minutes units
sec_t  out  4  current seconds tens
sec_u  out  4  current seconds units
running  out  1  high in RUN
done  out  1  high in ALARM
beep  out  1  buzzer enable, high in ALARM

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all digits 0; running=0, done=0, beep=0; beep tick counter 0. Reset mid-run discards the count immediately.
- States: IDLE, RUN, PAUSE, ALARM. All outputs are registered and reflect state and digits after the clock edge.
- Per-cycle priority: clear > load > start/stop > tick.
- clear: from any state, go to IDLE, zero the digits, drop beep.
- load: acted on only in IDLE or PAUSE; ignored in RUN and ALARM.
  - Accepted only if every digit is legal (tens ≤5, units ≤9). All four digits update on the same edge.
  - If any digit is illegal, the whole load is rejected and the digits are unchanged.
  - State is unchanged by load.
- start:
  - In IDLE or PAUSE with a nonzero count: go to RUN on the next edge.
  - With a 00:00 count: ignored.
  - In RUN: ignored.
- stop:
  - In RUN: go to PAUSE. The digits hold.
  - In IDLE or PAUSE: ignored.
- start and stop asserted together: both ignored, except in ALARM.
- ALARM acknowledge: in ALARM, start or stop goes to IDLE immediately. Digits stay 00:00 and beep drops.
- RUN decrement on tick, with a borrow chain:
  - sec_u 0 → 9 and borrows; otherwise sec_u − 1.
  - sec_t 0 → 5 on borrow and borrows; otherwise sec_t − 1.
  - min_u 0 → 9 on borrow and borrows; otherwise min_u − 1.
  - min_t − 1 on borrow.
- Count reaching zero: if a decrement produces 00:00, the same edge enters ALARM. done=1 and beep=1 from that edge; running=0.
- stop and tick in the same cycle in RUN: stop wins, no decrement, go to PAUSE.
- Ticks in IDLE and PAUSE have no effect.
- ALARM timing:
  - The beep counter clears on entry to ALARM.
  - Each tick increments it.
  - On the tick that makes the count equal BEEP_SECS, go to IDLE and drop done and beep.
- Legal-digit invariant: digits never leave the legal BCD range. Maximum count is 59:59; no wrap past 00:00.

Test Plan:
- Load 01:00 in IDLE, start, 1 tick → 00:59, running=1; another tick → 00:58.
- Load 10:00, start, 1 tick → 09:59 (full borrow chain); load asserted while RUN → digits unchanged.
- Load 00:02, start, 2 ticks → 00:00, done=1, beep=1 on the 2nd tick edge; 9 further ticks → still ALARM; 10th tick → IDLE, beep=0 (BEEP_SECS=10).
- RUN at 00:30, stop and tick in the same cycle → PAUSE, 00:30 held; 3 ticks → still 00:30; start, 1 tick → 00:29.
- Load 00:60 in IDLE → rejected, digits stay 00:00; start with 00:00 → stays IDLE.
- RUN at 05:00, rst_n low for 1 cycle mid-tick → 00:00, IDLE, all flags 0. ALARM then stop → IDLE next edge. clear during PAUSE at 03:15 → IDLE, 00:00.

Source files
------------

// File: rtl/countdown_timer_bcd_if.sv
// Control, preset and display/buzzer signals of the MM:SS countdown timer.
// The controller side is the master; the timer itself is the slave.
interface countdown_timer_bcd_if;
  logic       tick;
  logic       load;
  logic [3:0] load_min_t;
  logic [3:0] load_min_u;
  logic [3:0] load_sec_t;
  logic [3:0] load_sec_u;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       done;
  logic       beep;

  modport master (
    output tick, load, load_min_t, load_min_u, load_sec_t, load_sec_u,
           start, stop, clear,
    input  min_t, min_u, sec_t, sec_u, running, done, beep
  );

  modport slave (
    input  tick, load, load_min_t, load_min_u, load_sec_t, load_sec_u,
           start, stop, clear,
    output min_t, min_u, sec_t, sec_u, running, done, beep
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD down-counter with pause/resume and a timed alarm window at 00:00.
// Priority each cycle: clear > load > start/stop > tick.
module countdown_timer_bcd #(
  parameter int BEEP_SECS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  countdown_timer_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam logic [5:0] BEEP_LIMIT = 6'(BEEP_SECS);

  state_t     state, state_nx;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic [3:0] min_t_nx, min_u_nx, sec_t_nx, sec_u_nx;
  logic [5:0] beep_cnt, beep_cnt_nx;

  logic [3:0] min_t_dec, min_u_dec, sec_t_dec, sec_u_dec;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       load_legal, count_zero, dec_zero;
  logic [5:0] beep_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      min_t    <= 4'd0;
      min_u    <= 4'd0;
      sec_t    <= 4'd0;
      sec_u    <= 4'd0;
      beep_cnt <= 6'd0;
    end else begin
      state    <= state_nx;
      min_t    <= min_t_nx;
      min_u    <= min_u_nx;
      sec_t    <= sec_t_nx;
      sec_u    <= sec_u_nx;
      beep_cnt <= beep_cnt_nx;
    end
  end

  // Borrow chain: each digit wraps to its maximum only when the one below borrows.
  always_comb begin
    borrow_su = (sec_u == 4'd0);
    sec_u_dec = borrow_su ? 4'd9 : sec_u - 4'd1;
    borrow_st = borrow_su && (sec_t == 4'd0);
    sec_t_dec = borrow_su ? ((sec_t == 4'd0) ? 4'd5 : sec_t - 4'd1) : sec_t;
    borrow_mu = borrow_st && (min_u == 4'd0);
    min_u_dec = borrow_st ? ((min_u == 4'd0) ? 4'd9 : min_u - 4'd1) : min_u;
    min_t_dec = borrow_mu ? min_t - 4'd1 : min_t;
  end

  always_comb begin
    state_nx    = state;
    min_t_nx    = min_t;
    min_u_nx    = min_u;
    sec_t_nx    = sec_t;
    sec_u_nx    = sec_u;
    beep_cnt_nx = beep_cnt;

    load_legal   = (bus.load_min_t <= 4'd5) && (bus.load_min_u <= 4'd9) &&
                   (bus.load_sec_t <= 4'd5) && (bus.load_sec_u <= 4'd9);
    count_zero   = ({min_t, min_u, sec_t, sec_u} == 16'd0);
    dec_zero     = ({min_t_dec, min_u_dec, sec_t_dec, sec_u_dec} == 16'd0);
    beep_cnt_inc = beep_cnt + 6'd1;

    if (bus.clear) begin
      state_nx    = IDLE;
      min_t_nx    = 4'd0;
      min_u_nx    = 4'd0;
      sec_t_nx    = 4'd0;
      sec_u_nx    = 4'd0;
      beep_cnt_nx = 6'd0;
    end else if (bus.load && (state == IDLE || state == PAUSE)) begin
      if (load_legal) begin
        min_t_nx = bus.load_min_t;
        min_u_nx = bus.load_min_u;
        sec_t_nx = bus.load_sec_t;
        sec_u_nx = bus.load_sec_u;
      end
    end else begin
      unique case (state)
        IDLE, PAUSE: begin
          if (bus.start && !bus.stop && !count_zero) state_nx = RUN;
        end
        RUN: begin
          if (bus.stop && !bus.start) begin
            state_nx = PAUSE;
          end else if (bus.tick) begin
            min_t_nx = min_t_dec;
            min_u_nx = min_u_dec;
            sec_t_nx = sec_t_dec;
            sec_u_nx = sec_u_dec;
            if (dec_zero) begin
              state_nx    = ALARM;
              beep_cnt_nx = 6'd0;
            end
          end
        end
        ALARM: begin
          if (bus.start || bus.stop) begin
            state_nx    = IDLE;
            beep_cnt_nx = 6'd0;
          end else if (bus.tick) begin
            beep_cnt_nx = beep_cnt_inc;
            if (beep_cnt_inc == BEEP_LIMIT) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.min_t   = min_t;
    bus.min_u   = min_u;
    bus.sec_t   = sec_t;
    bus.sec_u   = sec_u;
    bus.running = (state == RUN);
    bus.done    = (state == ALARM);
    bus.beep    = (state == ALARM);
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: directed vector table, corner sequences and a
// randomized run against a seconds-based reference model.
module tb_countdown_timer_bcd;

  localparam int BEEP_SECS = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_bcd_if ifc ();
  countdown_timer_bcd #(.BEEP_SECS(BEEP_SECS)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int tests = 0;
  int failed = 0;

  // Reference model: total remaining seconds, a mode and the beep seconds elapsed.
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_beep = 0;

  typedef struct {
    bit          tick;
    bit          load;
    logic [15:0] preset;
    bit          start;
    bit          stop;
    bit          clear;
    logic [15:0] exp_digits;
    bit          exp_run;
    bit          exp_alarm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] to_bcd(int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_secs = 0;
    m_beep = 0;
  endfunction

  function automatic void model_step(bit tick, bit load, logic [15:0] p, bit start, bit stop, bit clear);
    bit legal;
    legal = (p[15:12] <= 5) && (p[11:8] <= 9) && (p[7:4] <= 5) && (p[3:0] <= 9);
    if (clear) begin
      model_reset();
    end else if (load && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
      if (legal) m_secs = (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
    end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
      if (start && !stop && m_secs != 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (stop && !start) m_mode = M_PAUSE;
      else if (tick) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_ALARM;
          m_beep = 0;
        end
      end
    end else begin
      if (start || stop) begin
        m_mode = M_IDLE;
        m_beep = 0;
      end else if (tick) begin
        m_beep = m_beep + 1;
        if (m_beep == BEEP_SECS) m_mode = M_IDLE;
      end
    end
  endfunction

  task automatic apply_stimulus(bit tick, bit load, logic [15:0] p, bit start, bit stop, bit clear);
    ifc.tick       = tick;
    ifc.load       = load;
    ifc.load_min_t = p[15:12];
    ifc.load_min_u = p[11:8];
    ifc.load_sec_t = p[7:4];
    ifc.load_sec_u = p[3:0];
    ifc.start      = start;
    ifc.stop       = stop;
    ifc.clear      = clear;
    model_step(tick, load, p, start, stop, clear);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [15:0] exp_d, bit exp_run, bit exp_alarm);
    logic [15:0] got_d;
    got_d = {ifc.min_t, ifc.min_u, ifc.sec_t, ifc.sec_u};
    tests++;
    if (got_d !== exp_d || ifc.running !== exp_run || ifc.done !== exp_alarm || ifc.beep !== exp_alarm) begin
      failed++;
      $display("[TB] FAIL %s: got %h run=%b done=%b beep=%b, want %h run=%b done=%b beep=%b",
               name, got_d, ifc.running, ifc.done, ifc.beep, exp_d, exp_run, exp_alarm, exp_alarm);
    end
  endtask

  task automatic check_model(string name);
    check_output(name, to_bcd(m_secs), m_mode == M_RUN, m_mode == M_ALARM);
  endtask

  task automatic idle_cycle();
    apply_stimulus(0, 0, 16'h0000, 0, 0, 0);
  endtask

  function automatic void add(bit t, bit l, logic [15:0] p, bit sa, bit so, bit c,
                              logic [15:0] ed, bit er, bit ea);
    vec_t v;
    v.tick = t; v.load = l; v.preset = p; v.start = sa; v.stop = so; v.clear = c;
    v.exp_digits = ed; v.exp_run = er; v.exp_alarm = ea;
    vecs.push_back(v);
  endfunction

  initial begin
    //   tick load preset  start stop clear  expected  run alarm
    add(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0058, 1, 0);
    add(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0959, 1, 0);
    add(0, 1, 16'h2345, 0, 0, 0, 16'h0959, 1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0959, 1, 0);
    add(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(0, 1, 16'h0060, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
    add(0, 1, 16'h5959, 0, 0, 0, 16'h5959, 0, 0);
    add(0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);

    apply_stimulus(0, 0, 16'h0000, 0, 0, 0);
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_output("reset", 16'h0000, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].tick, vecs[i].load, vecs[i].preset, vecs[i].start, vecs[i].stop, vecs[i].clear);
      check_output($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_run, vecs[i].exp_alarm);
    end

    // Alarm window lasts exactly BEEP_SECS ticks, with idle cycles between ticks.
    for (int k = 1; k <= BEEP_SECS; k++) begin
      idle_cycle();
      check_output($sformatf("alarm_gap%0d", k), 16'h0000, 0, 1);
      apply_stimulus(1, 0, 16'h0000, 0, 0, 0);
      check_output($sformatf("alarm_tick%0d", k), 16'h0000, 0, k < BEEP_SECS);
    end

    // Stop beats a simultaneous tick; ticks in PAUSE do nothing.
    apply_stimulus(0, 1, 16'h0030, 0, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0, 0);
    check_output("run_0030", 16'h0030, 1, 0);
    apply_stimulus(1, 0, 16'h0000, 0, 1, 0);
    check_output("stop_tick", 16'h0030, 0, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 0, 16'h0000, 0, 0, 0);
      check_output($sformatf("pause_tick%0d", k), 16'h0030, 0, 0);
    end
    apply_stimulus(0, 0, 16'h0000, 1, 0, 0);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 0);
    check_output("resume_tick", 16'h0029, 1, 0);

    // Asynchronous reset in the middle of a tick cycle while running.
    apply_stimulus(0, 0, 16'h0000, 0, 0, 1);
    apply_stimulus(0, 1, 16'h0500, 0, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0, 0);
    check_output("run_0500", 16'h0500, 1, 0);
    ifc.start = 1'b0;
    ifc.tick  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 16'h0000, 0, 0);
    @(posedge clk);
    #1;
    ifc.tick = 1'b0;
    rst_n = 1'b1;
    model_reset();
    check_output("after_reset", 16'h0000, 0, 0);

    // Acknowledge an alarm with stop.
    apply_stimulus(0, 1, 16'h0001, 0, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0, 0);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 0);
    check_output("alarm_0001", 16'h0000, 0, 1);
    apply_stimulus(0, 0, 16'h0000, 0, 1, 0);
    check_output("alarm_ack", 16'h0000, 0, 0);

    // Clear out of PAUSE.
    apply_stimulus(0, 1, 16'h0315, 0, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 0, 1, 0);
    check_output("pause_0315", 16'h0315, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 0, 0, 1);
    check_output("clear_pause", 16'h0000, 0, 0);

    // Randomized traffic, biased toward short presets so alarms occur often.
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] p;
      p[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
      p[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'd0;
      p[7:4]   = 4'($urandom_range(0, 6));
      p[3:0]   = 4'($urandom_range(0, 10));
      apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, p,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 79) == 0);
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
